// File: rtl/garage_door_pkg.sv
// Shared definitions for the garage door plant model.
//   door_state_t : door/motor state encoding
//   FC_*         : sticky fault code values reported on Fault_Code
package garage_door_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_OPENING = 2'd1,
        ST_CLOSING = 2'd2,
        ST_FAULT   = 2'd3
    } door_state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;  // no fault recorded
    localparam logic [1:0] FC_BOTH  = 2'b01;  // UP_M and DN_M driven together
    localparam logic [1:0] FC_STALL = 2'b10;  // motor driven but door not moving

endpackage

// File: rtl/garage_door_plant_model_door_step_timer.sv
// Step prescaler for the door plant: counts clock cycles while the motor is
// validly driven and pulses Tick on the last cycle of each STEP_DIV period.
//   CLK    : system clock, rising edge
//   RST    : asynchronous active-high reset
//   Enable : count while high
//   Clear  : force the prescaler to 0 (priority over Enable)
//   Tick   : high in the cycle whose closing edge performs a door step
module door_step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic Enable,
    input  logic Clear,
    output logic Tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Tick is a decode of the registered count, so it lines up with the edge
    // that wraps the prescaler back to 0.
    assign Tick = Enable && (cnt_r == CNT_LAST);

    // Prescaler: cleared when idle, wraps to 0 on each tick.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= '0;
        end else if (Clear || !Enable) begin
            cnt_r <= '0;
        end else if (Tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/garage_door_plant_model.sv
// Behavioural garage door plant: turns UP_M/DN_M motor commands into a door
// position and the UP_Max/DN_Max limit switches, flagging illegal drive and
// stall conditions.
//   CLK, RST     : clock (rising edge), asynchronous active-high reset
//   UP_M, DN_M   : motor drive up (open) / down (close)
//   Obstruct     : blocks any position change while high
//   Clr_Fault    : fault clear request (honoured only with both drives low)
//   UP_Max       : Position == TRAVEL
//   DN_Max       : Position == 0
//   Position     : door position 0..TRAVEL
//   Moving       : state is OPENING or CLOSING
//   Fault        : state is FAULT
//   Fault_Code   : FC_NONE / FC_BOTH / FC_STALL, sticky until cleared
module garage_door_plant_model
    import garage_door_pkg::*;
#(
    parameter  int TRAVEL    = 8,
    parameter  int STEP_DIV  = 4,
    parameter  int STALL_LIM = 3,
    parameter  int INIT_OPEN = 0,
    localparam int PW        = $clog2(TRAVEL + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          UP_M,
    input  logic          DN_M,
    input  logic          Obstruct,
    input  logic          Clr_Fault,
    output logic          UP_Max,
    output logic          DN_Max,
    output logic [PW-1:0] Position,
    output logic          Moving,
    output logic          Fault,
    output logic [1:0]    Fault_Code
);

    localparam int SW = $clog2(STALL_LIM + 1);

    localparam logic [PW-1:0] POS_MAX   = PW'(TRAVEL);
    localparam logic [PW-1:0] POS_MIN   = '0;
    localparam logic [PW-1:0] POS_ONE   = PW'(1);
    localparam logic [PW-1:0] POS_RESET = (INIT_OPEN != 0) ? POS_MAX : POS_MIN;
    localparam logic [SW-1:0] STALL_ONE = SW'(1);
    localparam logic [SW-1:0] STALL_TOP = SW'(STALL_LIM - 1);

    door_state_t   state_r;
    logic [PW-1:0] pos_r;
    logic [SW-1:0] stall_cnt_r;
    logic [1:0]    fault_code_r;

    logic          drive_ok_s;
    logic          blocked_s;
    logic [PW-1:0] next_pos_s;
    logic          tick_s;

    // Drive is valid only when exactly the own-direction input is high; any
    // other combination leaves the moving state, so the prescaler restarts.
    always_comb begin
        drive_ok_s = 1'b0;
        blocked_s  = 1'b0;
        next_pos_s = pos_r;
        if (state_r == ST_OPENING) begin
            drive_ok_s = UP_M && !DN_M;
            blocked_s  = Obstruct || (pos_r == POS_MAX);
            next_pos_s = pos_r + POS_ONE;
        end else if (state_r == ST_CLOSING) begin
            drive_ok_s = DN_M && !UP_M;
            blocked_s  = Obstruct || (pos_r == POS_MIN);
            next_pos_s = pos_r - POS_ONE;
        end else begin
            drive_ok_s = 1'b0;
            blocked_s  = 1'b0;
            next_pos_s = pos_r;
        end
    end

    door_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .CLK    (CLK),
        .RST    (RST),
        .Enable (drive_ok_s),
        .Clear  (!drive_ok_s),
        .Tick   (tick_s)
    );

    // Door state machine, position counter, stall counter and fault code.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_STOPPED;
            pos_r        <= POS_RESET;
            stall_cnt_r  <= '0;
            fault_code_r <= FC_NONE;
        end else begin
            case (state_r)
                ST_STOPPED: begin
                    stall_cnt_r <= '0;
                    if (UP_M && DN_M) begin
                        state_r      <= ST_FAULT;
                        fault_code_r <= FC_BOTH;
                    end else if (UP_M) begin
                        state_r <= ST_OPENING;
                    end else if (DN_M) begin
                        state_r <= ST_CLOSING;
                    end else begin
                        state_r <= ST_STOPPED;
                    end
                end
                ST_OPENING, ST_CLOSING: begin
                    if (UP_M && DN_M) begin
                        // Both-drive check outranks everything else.
                        state_r      <= ST_FAULT;
                        fault_code_r <= FC_BOTH;
                        stall_cnt_r  <= '0;
                    end else if (!drive_ok_s) begin
                        // Own input dropped or reversal: always pass through STOPPED.
                        state_r     <= ST_STOPPED;
                        stall_cnt_r <= '0;
                    end else if (tick_s) begin
                        if (blocked_s) begin
                            if (stall_cnt_r == STALL_TOP) begin
                                state_r      <= ST_FAULT;
                                fault_code_r <= FC_STALL;
                                stall_cnt_r  <= '0;
                            end else begin
                                stall_cnt_r <= stall_cnt_r + STALL_ONE;
                            end
                        end else begin
                            pos_r       <= next_pos_s;
                            stall_cnt_r <= '0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FAULT: begin
                    // Position is frozen; only a clean clear request exits.
                    if (Clr_Fault && !UP_M && !DN_M) begin
                        state_r      <= ST_STOPPED;
                        fault_code_r <= FC_NONE;
                    end else begin
                        state_r <= ST_FAULT;
                    end
                end
                default: begin
                    state_r      <= ST_STOPPED;
                    stall_cnt_r  <= '0;
                    fault_code_r <= FC_NONE;
                end
            endcase
        end
    end

    assign UP_Max     = (pos_r == POS_MAX);
    assign DN_Max     = (pos_r == POS_MIN);
    assign Position   = pos_r;
    assign Moving     = (state_r == ST_OPENING) || (state_r == ST_CLOSING);
    assign Fault      = (state_r == ST_FAULT);
    assign Fault_Code = fault_code_r;

endmodule

// File: tb/tb_garage_door_plant_model.sv
// Scoreboard bench for garage_door_plant_model. Stimulus processes push the
// expected outputs for a given edge count; a monitor on the falling edge pops
// and compares entries whose edge count has arrived.
module tb_garage_door_plant_model;

    logic       CLK = 1'b0;
    logic       RST, RST2;
    logic       UP_M, DN_M, Obstruct, Clr_Fault;
    logic       UP_M2, DN_M2, Obstruct2, Clr_Fault2;
    logic       UP_Max, DN_Max, Moving, Fault;
    logic       UP_Max2, DN_Max2, Moving2, Fault2;
    logic [3:0] Position, Position2;
    logic [1:0] Fault_Code, Fault_Code2;

    int  edge_cnt = 0;
    int  errors   = 0;
    int  checks   = 0;
    bit  done2    = 1'b0;

    typedef struct {
        int         cyc;
        bit         sel;
        string      tag;
        logic [3:0] pos;
        logic       up;
        logic       dn;
        logic       mov;
        logic       flt;
        logic [1:0] fc;
    } exp_t;

    exp_t sb_q[$];

    garage_door_plant_model dut (
        .CLK        (CLK),
        .RST        (RST),
        .UP_M       (UP_M),
        .DN_M       (DN_M),
        .Obstruct   (Obstruct),
        .Clr_Fault  (Clr_Fault),
        .UP_Max     (UP_Max),
        .DN_Max     (DN_Max),
        .Position   (Position),
        .Moving     (Moving),
        .Fault      (Fault),
        .Fault_Code (Fault_Code)
    );

    garage_door_plant_model #(.INIT_OPEN(1)) dut_open (
        .CLK        (CLK),
        .RST        (RST2),
        .UP_M       (UP_M2),
        .DN_M       (DN_M2),
        .Obstruct   (Obstruct2),
        .Clr_Fault  (Clr_Fault2),
        .UP_Max     (UP_Max2),
        .DN_Max     (DN_Max2),
        .Position   (Position2),
        .Moving     (Moving2),
        .Fault      (Fault2),
        .Fault_Code (Fault_Code2)
    );

    always #5 CLK = ~CLK;

    // Edge counter: edge 1 is the first rising edge after RST is released.
    always @(posedge CLK or posedge RST) begin
        if (RST) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic expect_at(input int cyc, input bit sel, input string tag,
                             input int pos, input bit up, input bit dn,
                             input bit mov, input bit flt, input logic [1:0] fc);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.tag = tag; e.pos = 4'(pos);
        e.up = up; e.dn = dn; e.mov = mov; e.flt = flt; e.fc = fc;
        sb_q.push_back(e);
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: compare every due entry on the falling edge.
    always @(negedge CLK) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= edge_cnt) begin
                exp_t e;
                logic [3:0] a_pos;
                logic a_up, a_dn, a_mov, a_flt;
                logic [1:0] a_fc;
                e = sb_q[i];
                sb_q.delete(i);
                if (e.sel) begin
                    a_pos = Position2; a_up = UP_Max2; a_dn = DN_Max2;
                    a_mov = Moving2;   a_flt = Fault2; a_fc = Fault_Code2;
                end else begin
                    a_pos = Position;  a_up = UP_Max;  a_dn = DN_Max;
                    a_mov = Moving;    a_flt = Fault;  a_fc = Fault_Code;
                end
                checks++;
                if (e.cyc != edge_cnt ||
                    a_pos !== e.pos || a_up !== e.up || a_dn !== e.dn ||
                    a_mov !== e.mov || a_flt !== e.flt || a_fc !== e.fc) begin
                    errors++;
                    $display("FAIL %s edge=%0d (due %0d): got pos=%0d up=%b dn=%b mov=%b flt=%b fc=%b, expected pos=%0d up=%b dn=%b mov=%b flt=%b fc=%b",
                             e.tag, edge_cnt, e.cyc, a_pos, a_up, a_dn, a_mov, a_flt, a_fc,
                             e.pos, e.up, e.dn, e.mov, e.flt, e.fc);
                end
            end
        end
    end

    // Second instance (INIT_OPEN=1): close to position 4, then reset mid-travel.
    initial begin
        RST2 = 1'b1; UP_M2 = 1'b0; DN_M2 = 1'b1; Obstruct2 = 1'b0; Clr_Fault2 = 1'b0;
        expect_at(0, 1'b1, "d2_reset_open", 8, 1, 0, 0, 0, 2'b00);
        #7 RST2 = 1'b0;
        expect_at(1,  1'b1, "d2_closing", 8, 1, 0, 1, 0, 2'b00);
        expect_at(5,  1'b1, "d2_first_step", 7, 0, 0, 1, 0, 2'b00);
        expect_at(13, 1'b1, "d2_pos5", 5, 0, 0, 1, 0, 2'b00);
        wait_edge(17);
        // Door has just reached 4; reset lands between clock edges.
        RST2 = 1'b1;
        #1;
        checks++;
        if (Position2 !== 4'd8) begin
            errors++;
            $display("FAIL d2_async_pos: got pos=%0d, expected 8 without a clock edge", Position2);
        end
        checks++;
        if (UP_Max2 !== 1'b1) begin
            errors++;
            $display("FAIL d2_async_upmax: got UP_Max=%b, expected 1", UP_Max2);
        end
        checks++;
        if (Moving2 !== 1'b0) begin
            errors++;
            $display("FAIL d2_async_moving: got Moving=%b, expected 0", Moving2);
        end
        expect_at(17, 1'b1, "d2_async_reset", 8, 1, 0, 0, 0, 2'b00);
        expect_at(20, 1'b1, "d2_reset_held", 8, 1, 0, 0, 0, 2'b00);
        wait_edge(21);
        DN_M2 = 1'b0;
        RST2  = 1'b0;
        done2 = 1'b1;
    end

    // Main instance stimulus.
    initial begin
        RST = 1'b1; UP_M = 1'b1; DN_M = 1'b0; Obstruct = 1'b0; Clr_Fault = 1'b0;
        expect_at(0, 1'b0, "s1_reset_closed", 0, 0, 1, 0, 0, 2'b00);
        #7 RST = 1'b0;

        // Full opening travel.
        expect_at(1,  1'b0, "s1_enter_opening", 0, 0, 1, 1, 0, 2'b00);
        expect_at(4,  1'b0, "s1_before_step",   0, 0, 1, 1, 0, 2'b00);
        expect_at(5,  1'b0, "s1_first_step",    1, 0, 0, 1, 0, 2'b00);
        expect_at(32, 1'b0, "s1_pos7",          7, 0, 0, 1, 0, 2'b00);
        expect_at(33, 1'b0, "s1_full_open",     8, 1, 0, 1, 0, 2'b00);

        // Driving into the open limit stalls.
        expect_at(44, 1'b0, "s2_blocked_no_fault", 8, 1, 0, 1, 0, 2'b00);
        expect_at(45, 1'b0, "s2_stall_fault",      8, 1, 0, 0, 1, 2'b10);
        expect_at(46, 1'b0, "s2_fault_hold",       8, 1, 0, 0, 1, 2'b10);
        wait_edge(46);
        checks++;
        if (Fault !== 1'b1) begin
            errors++;
            $display("FAIL s2_direct_fault: got Fault=%b, expected 1", Fault);
        end
        checks++;
        if (Fault_Code !== 2'b10) begin
            errors++;
            $display("FAIL s2_direct_code: got Fault_Code=%b, expected 10", Fault_Code);
        end
        UP_M = 1'b0; Clr_Fault = 1'b1;
        expect_at(47, 1'b0, "s2_cleared", 8, 1, 0, 0, 0, 2'b00);
        wait_edge(47);
        Clr_Fault = 1'b0;

        // Both drives from STOPPED; clear only with both low.
        wait_edge(48);
        UP_M = 1'b1; DN_M = 1'b1;
        expect_at(49, 1'b0, "s3_both_fault", 8, 1, 0, 0, 1, 2'b01);
        wait_edge(49);
        DN_M = 1'b0; Clr_Fault = 1'b1;
        expect_at(50, 1'b0, "s3_clr_ignored", 8, 1, 0, 0, 1, 2'b01);
        wait_edge(50);
        UP_M = 1'b0;
        expect_at(51, 1'b0, "s3_cleared", 8, 1, 0, 0, 0, 2'b00);
        wait_edge(51);
        Clr_Fault = 1'b0;

        // Closing with an 8-cycle obstruction at position 5.
        wait_edge(52);
        DN_M = 1'b1;
        expect_at(53, 1'b0, "s4_enter_closing", 8, 1, 0, 1, 0, 2'b00);
        expect_at(65, 1'b0, "s4_at5",           5, 0, 0, 1, 0, 2'b00);
        wait_edge(65);
        Obstruct = 1'b1;
        expect_at(73, 1'b0, "s4_obstructed", 5, 0, 0, 1, 0, 2'b00);
        wait_edge(73);
        Obstruct = 1'b0;
        expect_at(76, 1'b0, "s4_hold_before_resume", 5, 0, 0, 1, 0, 2'b00);
        expect_at(77, 1'b0, "s4_resume",             4, 0, 0, 1, 0, 2'b00);
        expect_at(93, 1'b0, "s4_closed",             0, 0, 1, 1, 0, 2'b00);
        wait_edge(93);
        DN_M = 1'b0;
        expect_at(94, 1'b0, "s4_stopped", 0, 0, 1, 0, 0, 2'b00);

        // Open to 3, then reverse.
        wait_edge(95);
        UP_M = 1'b1;
        expect_at(96,  1'b0, "s5_opening", 0, 0, 1, 1, 0, 2'b00);
        expect_at(108, 1'b0, "s5_at3",     3, 0, 0, 1, 0, 2'b00);
        wait_edge(108);
        UP_M = 1'b0; DN_M = 1'b1;
        expect_at(109, 1'b0, "s5_reversal_stop",    3, 0, 0, 0, 0, 2'b00);
        expect_at(110, 1'b0, "s5_closing",          3, 0, 0, 1, 0, 2'b00);
        expect_at(113, 1'b0, "s5_before_step",      3, 0, 0, 1, 0, 2'b00);
        expect_at(114, 1'b0, "s5_first_close_step", 2, 0, 0, 1, 0, 2'b00);
        wait_edge(114);
        DN_M = 1'b0;
        expect_at(115, 1'b0, "s5_stopped", 2, 0, 0, 0, 0, 2'b00);

        // Both drives while moving.
        wait_edge(116);
        UP_M = 1'b1;
        expect_at(117, 1'b0, "s6_opening", 2, 0, 0, 1, 0, 2'b00);
        wait_edge(118);
        DN_M = 1'b1;
        expect_at(119, 1'b0, "s6_both_while_moving", 2, 0, 0, 0, 1, 2'b01);
        wait_edge(119);
        UP_M = 1'b0; DN_M = 1'b0; Clr_Fault = 1'b1;
        expect_at(120, 1'b0, "s6_cleared", 2, 0, 0, 0, 0, 2'b00);
        wait_edge(120);
        Clr_Fault = 1'b0;

        wait_edge(124);
        wait (done2);
        @(negedge CLK);
        #1;
        foreach (sb_q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for edge %0d never compared", sb_q[i].tag, sb_q[i].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
